fifo_rr_write_arbiter: RTL and testbench
========================================

# fifo_rr_write_arbiter

Round-robin burst arbiter that shares the write port of one `synchronous_fifo` among `NUM_REQ` producers. It grants one requester at a time and holds the grant for up to `MAX_BURST` accepted beats. It muxes the owner's data onto the FIFO write port and stalls on `full`. It sits directly in front of the FIFO, and the FIFO read side is untouched.

## Interface
- `NUM_REQ`, default 4: number of requesters (≥2).
- `DATA_WIDTH`, default 8: word width; matches the FIFO.
- `MAX_BURST`, default 4: maximum accepted beats per grant (≥1).

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req` input `NUM_REQ`: per-requester request; bit i high means word valid on slice i of `req_data`.
- `req_data` input `NUM_REQ*DATA_WIDTH`: packed data; slice i is `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `gnt` output `NUM_REQ`: registered one-hot grant, or all zero.
- `ack` output `NUM_REQ`: per-requester beat accepted this cycle; the requester advances its data on `ack`.
- `fifo_full` input 1: FIFO `full`.
- `fifo_w_en` output 1: FIFO `w_en`.
- `fifo_data_in` output `DATA_WIDTH`: FIFO `data_in`.
- `owner_id` output `$clog2(NUM_REQ)`: index of the current owner; valid when state is GRANT.
- `beat_cnt` output `$clog2(MAX_BURST+1)`: beats accepted in the current grant.

## Operation
- FSM has two states.
- **IDLE**
  - `gnt` is 0.
  - If any `req` bit is high, pick the first set bit searching upward from `last_owner+1` with wrap.
  - On the next edge: go to GRANT, load `owner_id`, set `gnt`, clear `beat_cnt`.
- **GRANT**
  - Beat accepted iff `req[owner_id] && !fifo_full`.
  - On an accepted beat: `fifo_w_en=1`, `ack[owner_id]=1`, `beat_cnt` increments.
  - `fifo_data_in` always equals `req_data` slice `owner_id` in GRANT; it is 0 in IDLE.
- **Release**: leave GRANT for IDLE on the next edge when either
  - an accepted beat makes `beat_cnt` reach `MAX_BURST`, or
  - `req[owner_id]` is low (owner finished or withdrew).
  - On release: `last_owner <= owner_id`, `gnt` is cleared.
- **Stall**: `fifo_full` high in GRANT holds the grant indefinitely. `fifo_w_en`/`ack` stay 0 and `beat_cnt` holds. There is no timeout.
- **Requester rules**
  - Non-owner `req` bits are ignored.
  - Deasserting `req` without a prior `ack` loses no data, because nothing was written.
- **Combinational outputs**: `fifo_w_en` and `ack` are combinational from `req`, `fifo_full` and the registered state. `fifo_w_en` is never high while `fifo_full` is high.
- **Reset**: `gnt=0`, `ack=0`, `fifo_w_en=0`, `fifo_data_in=0`, `owner_id=0`, `beat_cnt=0`, state IDLE, `last_owner=NUM_REQ-1` (requester 0 has first priority).
  - Reset mid-burst aborts the grant; the beat in the reset cycle is still written if accepted.

## Timing
- `req` rises in cycle N while IDLE → `gnt` high in N+1 → first write in N+1 if not full.
- Sustained burst: one word per cycle, `MAX_BURST` words, then one IDLE bubble cycle before the next grant.
- Per-grant cost is `MAX_BURST+1` cycles with no stalls.
- Worst-case wait for a continuously requesting port, with no stalls: `(NUM_REQ-1)*(MAX_BURST+1)` cycles after it becomes eligible.
- Simultaneous requests: only the round-robin winner is granted; others wait with no starvation.

## Structure
- Package `fifo_arb_pkg` holds:
  - state enum typedef `arb_state_t` {IDLE, GRANT};
  - localparam helpers for `ID_W = $clog2(NUM_REQ)` and `CNT_W`.
- Sub-module `rr_priority_picker`: combinational; inputs `req` and `last_owner`; outputs `winner_id` and `any_req`. It is parameterised by `NUM_REQ` and uses a double-width rotate plus find-first.
- The top level holds the FSM, counters, data mux and ack decode.

## Test plan
- Requester 0 alone, 6 words `0x10`–`0x15`, FIFO never full:
  - words 0x10–0x13 on `fifo_w_en` in 4 consecutive cycles;
  - 1 IDLE cycle;
  - regrant to 0, then 0x14–0x15;
  - `beat_cnt` shows 4, then 2.
- All 4 requesting continuously, 12 words each → grant order 0,1,2,3,0,1,…, 4 beats per grant, 1-cycle gap; FIFO contents grouped in 4s by id.
- `fifo_full` forced high for 3 cycles after beat 2 of a burst → `fifo_w_en`/`ack` low those 3 cycles, `gnt` held, `beat_cnt`=2, then beats 3–4 complete.
- Requester 1 owns the grant and drops `req` after 2 beats while requester 2 is waiting → release next edge; `gnt[2]` one IDLE cycle later; `last_owner`=1.
- `rst` pulsed during beat 3 of requester 3's burst → next cycle all outputs at reset values; with all requesting, next grant goes to requester 0.
- Integrated with the real `synchronous_fifo`, random data, random `req` gaps, reader draining at 50% → per-id scoreboard shows every word read exactly once, in order, with no write while full.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   function automatic int id_w(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   function automatic int cnt_w(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request bit above last_owner, with wrap.
module rr_priority_picker
   import fifo_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_owner,
   output logic [ID_W-1:0]    winner_id,
   output logic               any_req
);

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [2*NUM_REQ-1:0] req_shift;
   logic [NUM_REQ-1:0]   req_rot;
   int unsigned          start;
   int unsigned          idx;
   logic                 found;

   always_comb begin
      start = 32'(last_owner) + 32'd1;
      if (start >= 32'(NUM_REQ)) start = 0;
      // Rotating a doubled copy puts the highest-priority requester at bit 0.
      req_dbl   = {req, req};
      req_shift = req_dbl >> start;
      req_rot   = req_shift[NUM_REQ-1:0];
      any_req   = |req;
      winner_id = '0;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned k = 0; k < 32'(NUM_REQ); k++) begin
         if (req_rot[k] && !found) begin
            found = 1'b1;
            idx   = start + k;
            if (idx >= 32'(NUM_REQ)) idx = idx - 32'(NUM_REQ);
            winner_id = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_rr_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 8,
   parameter  int MAX_BURST  = 4,
   localparam int ID_W       = id_w(NUM_REQ),
   localparam int CNT_W      = cnt_w(MAX_BURST)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            ack,
   input  logic                          fifo_full,
   output logic                          fifo_w_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   output logic [ID_W-1:0]               owner_id,
   output logic [CNT_W-1:0]              beat_cnt
);

   arb_state_t            state, state_nxt;
   logic [ID_W-1:0]       last_owner;
   logic [ID_W-1:0]       winner_id;
   logic                  any_req;
   logic                  owner_req;
   logic                  accept;
   logic [DATA_WIDTH-1:0] owner_data;

   rr_priority_picker #(
      .NUM_REQ(NUM_REQ)
   ) u_picker (
      .req       (req),
      .last_owner(last_owner),
      .winner_id (winner_id),
      .any_req   (any_req)
   );

   always_comb begin
      owner_req  = req[owner_id];
      owner_data = '0;
      for (int unsigned i = 0; i < 32'(NUM_REQ); i++) begin
         if (owner_id == ID_W'(i)) owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      accept       = (state == GRANT) && owner_req && !fifo_full;
      fifo_w_en    = accept;
      ack          = '0;
      if (accept) ack[owner_id] = 1'b1;
      fifo_data_in = (state == GRANT) ? owner_data : '0;

      state_nxt = state;
      case (state)
         IDLE:  if (any_req) state_nxt = GRANT;
         GRANT: if (!owner_req || (accept && beat_cnt == CNT_W'(MAX_BURST - 1)))
                   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         gnt        <= '0;
         owner_id   <= '0;
         beat_cnt   <= '0;
         last_owner <= ID_W'(NUM_REQ - 1);
      end else begin
         state <= state_nxt;
         if (state == IDLE && state_nxt == GRANT) begin
            owner_id <= winner_id;
            gnt      <= NUM_REQ'(1) << winner_id;
            beat_cnt <= '0;
         end
         if (accept) beat_cnt <= beat_cnt + CNT_W'(1);
         // owner_id and beat_cnt deliberately hold through IDLE until the next grant.
         if (state == GRANT && state_nxt == IDLE) begin
            last_owner <= owner_id;
            gnt        <= '0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Directed, table-driven bench for fifo_rr_write_arbiter plus round-robin burst sequence.
module tb_fifo_rr_write_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NR-1:0] req;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0] gnt, ack;
   logic          fifo_full;
   logic          fifo_w_en;
   logic [DW-1:0] fifo_data_in;
   logic [1:0]    owner_id;
   logic [2:0]    beat_cnt;

   int tests  = 0;
   int failed = 0;

   fifo_rr_write_arbiter #(
      .NUM_REQ(NR),
      .DATA_WIDTH(DW),
      .MAX_BURST(MB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_data    (req_data),
      .gnt         (gnt),
      .ack         (ack),
      .fifo_full   (fifo_full),
      .fifo_w_en   (fifo_w_en),
      .fifo_data_in(fifo_data_in),
      .owner_id    (owner_id),
      .beat_cnt    (beat_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [31:0] rdata;
      logic        full;
      logic [3:0]  e_gnt;
      logic [3:0]  e_ack;
      logic        e_wen;
      logic [7:0]  e_data;
      logic [1:0]  e_owner;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic [3:0] q, logic [31:0] d, logic f,
                               logic [3:0] g, logic [3:0] a, logic w,
                               logic [7:0] o, logic [1:0] id, logic [2:0] c);
      vec_t v;
      v.rst = r; v.req = q; v.rdata = d; v.full = f;
      v.e_gnt = g; v.e_ack = a; v.e_wen = w; v.e_data = o; v.e_owner = id; v.e_cnt = c;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s[%0d] got %h expected %h", name, idx, got, exp);
      end
   endtask

   int wcnt[NR];
   int k;

   initial begin
      rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
      @(posedge clk);

      vecs.push_back(mk(1, 4'h0, 32'h0,        0, 4'h0, 4'h0, 0, 8'h00, 0, 0)); // reset state
      // requester 0 alone, 6 words
      vecs.push_back(mk(0, 4'h1, 32'h10,       0, 4'h0, 4'h0, 0, 8'h00, 0, 0));
      vecs.push_back(mk(0, 4'h1, 32'h10,       0, 4'h1, 4'h1, 1, 8'h10, 0, 0));
      vecs.push_back(mk(0, 4'h1, 32'h11,       0, 4'h1, 4'h1, 1, 8'h11, 0, 1));
      vecs.push_back(mk(0, 4'h1, 32'h12,       0, 4'h1, 4'h1, 1, 8'h12, 0, 2));
      vecs.push_back(mk(0, 4'h1, 32'h13,       0, 4'h1, 4'h1, 1, 8'h13, 0, 3));
      vecs.push_back(mk(0, 4'h1, 32'h14,       0, 4'h0, 4'h0, 0, 8'h00, 0, 4));
      vecs.push_back(mk(0, 4'h1, 32'h14,       0, 4'h1, 4'h1, 1, 8'h14, 0, 0));
      vecs.push_back(mk(0, 4'h1, 32'h15,       0, 4'h1, 4'h1, 1, 8'h15, 0, 1));
      vecs.push_back(mk(0, 4'h0, 32'h15,       0, 4'h1, 4'h0, 0, 8'h15, 0, 2));
      vecs.push_back(mk(0, 4'h0, 32'h0,        0, 4'h0, 4'h0, 0, 8'h00, 0, 2));
      // requester 1 burst with a 3-cycle full stall after beat 2
      vecs.push_back(mk(0, 4'h2, 32'h2000,     0, 4'h0, 4'h0, 0, 8'h00, 0, 2));
      vecs.push_back(mk(0, 4'h2, 32'h2000,     0, 4'h2, 4'h2, 1, 8'h20, 1, 0));
      vecs.push_back(mk(0, 4'h2, 32'h2100,     0, 4'h2, 4'h2, 1, 8'h21, 1, 1));
      vecs.push_back(mk(0, 4'h2, 32'h2200,     1, 4'h2, 4'h0, 0, 8'h22, 1, 2));
      vecs.push_back(mk(0, 4'h2, 32'h2200,     1, 4'h2, 4'h0, 0, 8'h22, 1, 2));
      vecs.push_back(mk(0, 4'h2, 32'h2200,     1, 4'h2, 4'h0, 0, 8'h22, 1, 2));
      vecs.push_back(mk(0, 4'h2, 32'h2200,     0, 4'h2, 4'h2, 1, 8'h22, 1, 2));
      vecs.push_back(mk(0, 4'h2, 32'h2300,     0, 4'h2, 4'h2, 1, 8'h23, 1, 3));
      vecs.push_back(mk(0, 4'h0, 32'h0,        0, 4'h0, 4'h0, 0, 8'h00, 1, 4));
      // requester 1 drops after 2 beats while 2 waits
      vecs.push_back(mk(0, 4'h2, 32'h3000,     0, 4'h0, 4'h0, 0, 8'h00, 1, 4));
      vecs.push_back(mk(0, 4'h6, 32'h0040_3000, 0, 4'h2, 4'h2, 1, 8'h30, 1, 0));
      vecs.push_back(mk(0, 4'h6, 32'h0040_3100, 0, 4'h2, 4'h2, 1, 8'h31, 1, 1));
      vecs.push_back(mk(0, 4'h4, 32'h0040_3100, 0, 4'h2, 4'h0, 0, 8'h31, 1, 2));
      vecs.push_back(mk(0, 4'h4, 32'h0040_0000, 0, 4'h0, 4'h0, 0, 8'h00, 1, 2));
      vecs.push_back(mk(0, 4'h4, 32'h0040_0000, 0, 4'h4, 4'h4, 1, 8'h40, 2, 0));
      vecs.push_back(mk(0, 4'h0, 32'h0041_0000, 0, 4'h4, 4'h0, 0, 8'h41, 2, 1));
      vecs.push_back(mk(0, 4'h0, 32'h0,        0, 4'h0, 4'h0, 0, 8'h00, 2, 1));
      // reset during beat 3 of requester 3, then all requesting
      vecs.push_back(mk(0, 4'h8, 32'h5000_0000, 0, 4'h0, 4'h0, 0, 8'h00, 2, 1));
      vecs.push_back(mk(0, 4'h8, 32'h5000_0000, 0, 4'h8, 4'h8, 1, 8'h50, 3, 0));
      vecs.push_back(mk(0, 4'h8, 32'h5100_0000, 0, 4'h8, 4'h8, 1, 8'h51, 3, 1));
      vecs.push_back(mk(1, 4'h8, 32'h5200_0000, 0, 4'h8, 4'h8, 1, 8'h52, 3, 2));
      vecs.push_back(mk(0, 4'hf, 32'h5362_6160, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0));
      vecs.push_back(mk(0, 4'hf, 32'h5362_6160, 0, 4'h1, 4'h1, 1, 8'h60, 0, 0));
      vecs.push_back(mk(0, 4'h0, 32'h5362_6160, 0, 4'h1, 4'h0, 0, 8'h60, 0, 1));

      foreach (vecs[i]) begin
         @(negedge clk);
         rst = vecs[i].rst; req = vecs[i].req; req_data = vecs[i].rdata; fifo_full = vecs[i].full;
         #1;
         chk("gnt",      i, 32'(gnt),          32'(vecs[i].e_gnt));
         chk("ack",      i, 32'(ack),          32'(vecs[i].e_ack));
         chk("w_en",     i, 32'(fifo_w_en),    32'(vecs[i].e_wen));
         chk("data_in",  i, 32'(fifo_data_in), 32'(vecs[i].e_data));
         chk("owner_id", i, 32'(owner_id),     32'(vecs[i].e_owner));
         chk("beat_cnt", i, 32'(beat_cnt),     32'(vecs[i].e_cnt));
      end

      // All four requesting continuously, 12 words each.
      @(negedge clk);
      rst = 1'b1; req = '0; fifo_full = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      foreach (wcnt[i]) wcnt[i] = 0;
      k = 0;
      for (int c = 0; c < 80; c++) begin
         if (c > 0) @(negedge clk);
         for (int i = 0; i < NR; i++) begin
            req[i] = (wcnt[i] < 12);
            req_data[i*DW +: DW] = 8'(i * 16 + wcnt[i]);
         end
         #1;
         chk("gnt_onehot0", c, 32'($onehot0(gnt)), 32'd1);
         if (fifo_w_en) begin
            chk("rr_data",  k, 32'(fifo_data_in),
                32'(((k / 4) % 4) * 16 + (k / 16) * 4 + (k % 4)));
            chk("rr_cycle", k, c, (k / 4) * 5 + 1 + (k % 4));
            k++;
         end
         for (int i = 0; i < NR; i++) if (ack[i]) wcnt[i]++;
      end
      chk("rr_total_writes", 0, k, 48);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
